// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive deframer.
package rmii_pkg;

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_e;

   localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
   localparam logic [1:0]  SFD_DIBIT       = 2'b11;
   localparam int unsigned DIBITS_PER_BYTE = 4;
   localparam int unsigned BYTE_W          = 8;

   // One stream beat as held in the pending and output registers.
   typedef struct packed {
      logic              last;
      logic              user;
      logic [BYTE_W-1:0] data;
   } axis_beat_t;

endpackage

// File: rtl/rmii_rx_deframer_if.sv
// Byte stream (valid/ready with last/user sideband) leaving the RMII deframer.
interface rmii_rx_deframer_if;

   logic [rmii_pkg::BYTE_W-1:0] tdata;
   logic                        tvalid;
   logic                        tready;
   logic                        tlast;
   logic                        tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/rmii_byte_assembler.sv
// Shifts committed RMII dibits (LSB first) into bytes; flags byte completion
// and reports when the dibit count is not on a byte boundary.
module rmii_byte_assembler
   import rmii_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              dibit_valid,
   input  logic [1:0]        dibit,
   output logic [BYTE_W-1:0] byte_c,
   output logic              byte_done_c,
   output logic              misaligned_c
);

   localparam int unsigned DCNT_W = $clog2(DIBITS_PER_BYTE);

   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [DCNT_W-1:0] cnt_q, cnt_d;

   // New dibit enters at the top so the first dibit ends up in bits [1:0].
   always_comb begin
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      byte_c      = {dibit, shift_q[BYTE_W-1:2]};
      byte_done_c = 1'b0;
      if (clear) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (dibit_valid) begin
         shift_d     = byte_c;
         cnt_d       = cnt_q + DCNT_W'(1);
         byte_done_c = (cnt_q == DCNT_W'(DIBITS_PER_BYTE - 1));
      end
   end

   assign misaligned_c = (cnt_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII 100 Mb/s receive front end: strips preamble/SFD, assembles bytes and
// emits frames as a byte stream with last/error sideband plus status counters.
module rmii_rx_deframer
   import rmii_pkg::*;
#(
   parameter int unsigned MAX_FRAME = 1522,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                clk_0,
   input  logic                reset_n_0,
   input  logic                phy2rmii_crs_dv_0,
   input  logic                phy2rmii_rx_er_0,
   input  logic [1:0]          phy2rmii_rxd_0,
   rmii_rx_deframer_if.master  m_axis,
   output logic [CNT_W-1:0]    frame_count,
   output logic [CNT_W-1:0]    err_count,
   output logic                rx_active
);

   localparam int unsigned LEN_W = $clog2(MAX_FRAME + 2);

   logic              crs_d1_q, crs_d1_d, er_d1_q, er_d1_d;
   logic [1:0]        rxd_d1_q, rxd_d1_d;
   logic              crs_hd_q, crs_hd_d, er_hd_q, er_hd_d;
   logic [1:0]        rxd_hd_q, rxd_hd_d;
   rx_state_e         state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              err_q, err_d;
   logic              pend_vld_q, pend_vld_d;
   axis_beat_t        pend_q, pend_d;
   logic              out_vld_q, out_vld_d;
   axis_beat_t        out_q, out_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
   logic              rx_active_q, rx_active_d;

   logic              eof_c, out_free_c;
   logic              asm_clear_c, asm_valid_c, asm_done_c, asm_misaligned_c;
   logic [BYTE_W-1:0] asm_byte_c;

   // Held dibit is committed unless it and its successor both lack carrier.
   assign eof_c       = ~crs_hd_q & ~crs_d1_q;
   assign out_free_c  = ~out_vld_q | m_axis.tready;
   assign asm_valid_c = (state_q == DATA) & ~eof_c;
   assign asm_clear_c = (state_q == PREAMBLE) & ~eof_c & (rxd_hd_q == SFD_DIBIT);

   rmii_byte_assembler u_asm (
      .clk          (clk_0),
      .rst_n        (reset_n_0),
      .clear        (asm_clear_c),
      .dibit_valid  (asm_valid_c),
      .dibit        (rxd_hd_q),
      .byte_c       (asm_byte_c),
      .byte_done_c  (asm_done_c),
      .misaligned_c (asm_misaligned_c)
   );

   always_comb begin
      crs_d1_d    = phy2rmii_crs_dv_0;
      er_d1_d     = phy2rmii_rx_er_0;
      rxd_d1_d    = phy2rmii_rxd_0;
      crs_hd_d    = crs_d1_q;
      er_hd_d     = er_d1_q;
      rxd_hd_d    = rxd_d1_q;
      state_d     = state_q;
      len_d       = len_q;
      err_d       = err_q;
      pend_vld_d  = pend_vld_q;
      pend_d      = pend_q;
      out_vld_d   = out_vld_q;
      out_d       = out_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;

      if (out_vld_q && m_axis.tready) begin
         out_vld_d = 1'b0;
         if (out_q.last) begin
            if (out_q.user) begin
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
               if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
         end
      end

      // A closed (last-marked) pending byte leaves as soon as the output frees.
      if (pend_vld_q && pend_q.last && out_free_c) begin
         out_vld_d  = 1'b1;
         out_d      = pend_q;
         pend_vld_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (crs_hd_q) begin
               if (pend_vld_q)                      state_d = DROP;
               else if (rxd_hd_q == PREAMBLE_DIBIT) state_d = PREAMBLE;
            end
         end
         PREAMBLE: begin
            if (eof_c) begin
               state_d = IDLE;
            end else if (rxd_hd_q == SFD_DIBIT) begin
               state_d = DATA;
               len_d   = '0;
               err_d   = 1'b0;
            end else if (rxd_hd_q != PREAMBLE_DIBIT) begin
               state_d = DROP;
            end
         end
         DATA: begin
            if (er_hd_q && crs_hd_q) err_d = 1'b1;
            if (eof_c) begin
               state_d = IDLE;
               if (pend_vld_q) begin
                  pend_d.last = 1'b1;
                  pend_d.user = err_q | asm_misaligned_c;
               end
            end else if (asm_done_c) begin
               if (len_q >= LEN_W'(MAX_FRAME)) begin
                  state_d = DROP;
                  err_d   = 1'b1;
                  if (pend_vld_q) begin
                     pend_d.last = 1'b1;
                     pend_d.user = 1'b1;
                  end
               end else if (pend_vld_q && !out_free_c) begin
                  // Consumer stalled too long: close the frame on the pending byte.
                  state_d     = DROP;
                  err_d       = 1'b1;
                  pend_d.last = 1'b1;
                  pend_d.user = 1'b1;
               end else begin
                  len_d = len_q + LEN_W'(1);
                  if (pend_vld_q) begin
                     out_vld_d = 1'b1;
                     out_d     = pend_q;
                  end
                  pend_vld_d  = 1'b1;
                  pend_d.last = 1'b0;
                  pend_d.user = 1'b0;
                  pend_d.data = asm_byte_c;
               end
            end
         end
         DROP: begin
            if (eof_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      rx_active_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_0 or negedge reset_n_0) begin
      if (!reset_n_0) begin
         crs_d1_q    <= 1'b0;
         er_d1_q     <= 1'b0;
         rxd_d1_q    <= '0;
         crs_hd_q    <= 1'b0;
         er_hd_q     <= 1'b0;
         rxd_hd_q    <= '0;
         state_q     <= IDLE;
         len_q       <= '0;
         err_q       <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_q      <= '0;
         out_vld_q   <= 1'b0;
         out_q       <= '0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         rx_active_q <= 1'b0;
      end else begin
         crs_d1_q    <= crs_d1_d;
         er_d1_q     <= er_d1_d;
         rxd_d1_q    <= rxd_d1_d;
         crs_hd_q    <= crs_hd_d;
         er_hd_q     <= er_hd_d;
         rxd_hd_q    <= rxd_hd_d;
         state_q     <= state_d;
         len_q       <= len_d;
         err_q       <= err_d;
         pend_vld_q  <= pend_vld_d;
         pend_q      <= pend_d;
         out_vld_q   <= out_vld_d;
         out_q       <= out_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         rx_active_q <= rx_active_d;
      end
   end

   assign m_axis.tvalid = out_vld_q;
   assign m_axis.tdata  = out_q.data;
   assign m_axis.tlast  = out_q.last;
   assign m_axis.tuser  = out_q.user;
   assign frame_count   = frame_cnt_q;
   assign err_count     = err_cnt_q;
   assign rx_active     = rx_active_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer: drives RMII frames and compares the
// captured byte stream and counters against hand-derived expectations.
`timescale 1ns/1ps
module tb_rmii_rx_deframer;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        crs   = 1'b0;
   logic        er    = 1'b0;
   logic [1:0]  rxd   = 2'b00;
   logic [15:0] frame_count, err_count;
   logic        rx_active;

   rmii_rx_deframer_if axis ();

   rmii_rx_deframer #(.MAX_FRAME(1522), .CNT_W(16)) dut (
      .clk_0             (clk),
      .reset_n_0         (rst_n),
      .phy2rmii_crs_dv_0 (crs),
      .phy2rmii_rx_er_0  (er),
      .phy2rmii_rxd_0    (rxd),
      .m_axis            (axis.master),
      .frame_count       (frame_count),
      .err_count         (err_count),
      .rx_active         (rx_active)
   );

   always #10 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Consumer model: captures accepted beats and stalls once on byte 0x03 when armed.
   logic [9:0] beats[$];
   bit         bp_arm    = 1'b0;
   bit         bp_done   = 1'b0;
   int         hold_cnt  = 0;
   int         hold_seen = 0;
   int         hold_bad  = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         axis.tready = 1'b1;
      end else if (hold_cnt != 0) begin
         hold_seen++;
         if (!(axis.tvalid && !axis.tlast && axis.tdata == 8'h03)) hold_bad++;
         hold_cnt--;
         if (hold_cnt == 0) axis.tready = 1'b1;
      end else if (bp_arm && !bp_done && axis.tvalid && axis.tdata == 8'h03) begin
         axis.tready = 1'b0;
         hold_cnt    = 9;
         bp_done     = 1'b1;
      end
      if (rst_n && axis.tvalid && axis.tready)
         beats.push_back({axis.tlast, axis.tuser, axis.tdata});
   end

   int rd_idx = 0;

   task automatic drive(input logic c, input logic e, input logic [1:0] d);
      @(negedge clk);
      crs = c;
      er  = e;
      rxd = d;
   endtask

   // Odd dibits (1st and 3rd) drop carrier for one cycle when tog is set.
   task automatic send_byte(input logic [7:0] b, input bit tog, input bit er_mid);
      for (int j = 0; j < 4; j++)
         drive((tog && (j == 0 || j == 2)) ? 1'b0 : 1'b1, er_mid && (j == 1), b[2*j +: 2]);
   endtask

   task automatic send_frame(input int nbytes, input logic [7:0] start, input bit tog,
                             input int er_byte, input int extra);
      for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0, 1'b0);
      send_byte(8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < nbytes; i++)
         send_byte(8'(start + 8'(i)), tog && (i >= nbytes - 4), i == er_byte);
      for (int i = 0; i < extra; i++) drive(1'b1, 1'b0, 2'b10);
      repeat (40) drive(1'b0, 1'b0, 2'b00);
   endtask

   task automatic check_frame(input string tag, input int n, input logic [7:0] start,
                              input logic exp_user);
      int   got_n;
      logic lst;
      got_n = beats.size() - rd_idx;
      chk({tag, "_beats"}, 32'(got_n), 32'(n));
      for (int i = 0; i < n && i < got_n; i++) begin
         lst = (i == n - 1);
         chk(tag, 32'(beats[rd_idx + i]), {22'd0, lst, lst & exp_user, 8'(start + 8'(i))});
      end
      rd_idx = beats.size();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
      chk("rst_tdata", {22'd0, axis.tlast, axis.tuser, axis.tdata}, 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_rx_active", 32'(rx_active), 32'd0);
      rst_n = 1'b1;
      repeat (5) drive(1'b0, 1'b0, 2'b00);

      send_frame(64, 8'h01, 1'b0, -1, 0);
      check_frame("clean", 64, 8'h01, 1'b0);
      chk("clean_frame_count", 32'(frame_count), 32'd1);
      chk("clean_err_count", 32'(err_count), 32'd0);
      chk("idle_rx_active", 32'(rx_active), 32'd0);

      send_frame(64, 8'h01, 1'b1, -1, 0);
      check_frame("crs_toggle", 64, 8'h01, 1'b0);
      chk("toggle_frame_count", 32'(frame_count), 32'd2);

      send_frame(60, 8'h41, 1'b0, 30, 0);
      check_frame("rx_er", 60, 8'h41, 1'b1);
      chk("rx_er_err_count", 32'(err_count), 32'd1);
      chk("rx_er_frame_count", 32'(frame_count), 32'd2);

      send_frame(20, 8'h21, 1'b0, -1, 2);
      check_frame("misalign", 20, 8'h21, 1'b1);
      chk("misalign_err_count", 32'(err_count), 32'd2);

      bp_arm = 1'b1;
      send_frame(30, 8'h01, 1'b0, -1, 0);
      check_frame("backpressure", 4, 8'h01, 1'b1);
      chk("bp_hold_cycles", 32'(hold_seen), 32'd9);
      chk("bp_hold_stable", 32'(hold_bad), 32'd0);
      chk("bp_err_count", 32'(err_count), 32'd3);

      send_frame(16, 8'h80, 1'b0, -1, 0);
      check_frame("after_bp", 16, 8'h80, 1'b0);
      chk("after_bp_frame_count", 32'(frame_count), 32'd3);

      send_frame(1600, 8'h00, 1'b0, -1, 0);
      check_frame("oversize", 1522, 8'h00, 1'b1);
      chk("oversize_err_count", 32'(err_count), 32'd4);
      chk("oversize_frame_count", 32'(frame_count), 32'd3);

      // Reset in the middle of a frame, then a fresh frame must still be received.
      for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0, 1'b0);
      send_byte(8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + 8'(i)), 1'b0, 1'b0);
      chk("midframe_rx_active", 32'(rx_active), 32'd1);
      rst_n = 1'b0;
      crs   = 1'b0;
      #1;
      chk("midrst_tvalid", 32'(axis.tvalid), 32'd0);
      chk("midrst_counts", {frame_count, err_count}, 32'd0);
      chk("midrst_rx_active", 32'(rx_active), 32'd0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      rd_idx = beats.size();
      repeat (5) drive(1'b0, 1'b0, 2'b00);
      send_frame(10, 8'h90, 1'b0, -1, 0);
      check_frame("post_reset", 10, 8'h90, 1'b0);
      chk("post_reset_frame_count", 32'(frame_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
